// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and pipe_ctrl.
// master = pipeline side (raises requests), slave = controller side.
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int CNT_W  = 32
);
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [31:0]       flush_pc;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] flush;
  logic              new_pc_valid;
  logic [31:0]       new_pc;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall_timeout;

  modport master (
    output stallreq, flush_req, flush_pc,
    input  stall, flush, new_pc_valid, new_pc, stall_cnt, stall_timeout
  );

  modport slave (
    input  stallreq, flush_req, flush_pc,
    output stall, flush, new_pc_valid, new_pc, stall_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: stall decode, flush sequencer with recovery
// window, saturating stall counter; stall watchdog enabled by PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter int STAGES         = 6,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32,
  parameter int WDOG_LIMIT     = 1024
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        rec_cnt_reg, rec_cnt_next;
  logic [STAGES-1:0] req_eff;
  logic [STAGES-1:0] stall_vec;
  logic [STAGES-1:0] flush_reg;
  logic              new_pc_valid_reg;
  logic [31:0]       new_pc_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;

  always_comb begin
    state_next   = state_reg;
    rec_cnt_next = rec_cnt_reg;
    req_eff      = bus.stallreq;
    case (state_reg)
      IDLE: begin
        if (bus.flush_req) state_next = FLUSH;
      end
      FLUSH: begin
        req_eff      = '0;
        rec_cnt_next = 4'(RECOVER_CYCLES);
        state_next   = bus.flush_req ? FLUSH : RECOVER;
      end
      RECOVER: begin
        // Downstream requests are stale after a redirect; only the PC may still hold.
        req_eff      = {{(STAGES-1){1'b0}}, bus.stallreq[0]};
        rec_cnt_next = rec_cnt_reg - 4'd1;
        if (bus.flush_req)          state_next = FLUSH;
        else if (rec_cnt_reg == 4'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage j holds when any stage at or below it in the pipe requests a stall.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_dec
      assign stall_vec[gi] = |req_eff[STAGES-1:gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      rec_cnt_reg      <= '0;
      flush_reg        <= '0;
      new_pc_valid_reg <= 1'b0;
      new_pc_reg       <= '0;
      stall_cnt_reg    <= '0;
    end else begin
      state_reg        <= state_next;
      rec_cnt_reg      <= rec_cnt_next;
      flush_reg        <= {STAGES{bus.flush_req}};
      new_pc_valid_reg <= bus.flush_req;
      if (bus.flush_req) new_pc_reg <= bus.flush_pc;
      if (stall_vec[0] && stall_cnt_reg != {CNT_W{1'b1}})
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

`ifdef PIPE_CTRL_WDOG_EN
  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  logic [WD_W-1:0] wdog_cnt_reg;
  logic            timeout_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (state_reg == FLUSH || !stall_vec[0])
        wdog_cnt_reg <= '0;
      else if (wdog_cnt_reg != WD_W'(WDOG_LIMIT))
        wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
      if (stall_vec[0] && wdog_cnt_reg == WD_W'(WDOG_LIMIT - 1))
        timeout_reg <= 1'b1;
    end
  end

  assign bus.stall_timeout = timeout_reg;
`else
  assign bus.stall_timeout = 1'b0;
`endif

  assign bus.stall        = rst ? '0 : stall_vec;
  assign bus.flush        = flush_reg;
  assign bus.new_pc_valid = new_pc_valid_reg;
  assign bus.new_pc       = new_pc_reg;
  assign bus.stall_cnt    = stall_cnt_reg;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline stall/flush controller for the five-stage core. It generalises the fixed stall-bus controller to `STAGES` stall bits with a request input per stage. It adds a registered flush sequencer that redirects the PC, and a post-flush recovery window that masks stale stall requests. It also keeps a saturating stall-cycle counter and an optional stall watchdog. It sits beside IF/ID/EX/MEM/WB: it collects their stall requests and drives the stall and flush vectors back to every stage.

## Interface
- `STAGES`, 6, width of the stall and flush vectors.
  - bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.
- `RECOVER_CYCLES`, 2, number of cycles after a flush during which stall requests are masked.
  - Legal range is 1..15.
- `CNT_W`, 32, width of the stall-cycle counter.
- `WDOG_LIMIT`, 1024, count of consecutive PC-stall cycles that raises the timeout.
  - Must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stallreq`  in  STAGES  bit i set: stage i requests that stage i and every upstream stage hold.
- `flush_req`  in  1  single-cycle redirect request (exception or eret).
- `flush_pc`  in  32  redirect target, sampled with `flush_req`.
- `stall`  out  STAGES  hold vector; bit j set means stage j holds its register.
- `flush`  out  STAGES  bit j set means stage j clears its register to a bubble.
- `new_pc_valid`  out  1  PC must load `new_pc` this cycle.
- `new_pc`  out  32  registered redirect target.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall[0]`=1.
- `stall_timeout`  out  1  sticky watchdog flag.

## Operation
- **Stall decode** (combinational from `stallreq` and state):
  - k = highest set index of `stallreq`.
  - `stall[j]`=1 for all j ≤ k; `stall[j]`=0 for j > k.
  - No request gives `stall`=0.
  - Example, STAGES=6 with EX requesting: `stall`=6'b001111.
- **FSM states:** IDLE, FLUSH, RECOVER.
  - IDLE: stall decode active and `flush`=0.
    - `flush_req`=1 latches `flush_pc` into `new_pc` and moves to FLUSH.
  - FLUSH (exactly 1 cycle):
    - `flush` = all ones, `new_pc_valid`=1, `stall`=0.
    - Loads the recovery counter with RECOVER_CYCLES, then moves to RECOVER.
  - RECOVER:
    - `stallreq` bits 1..STAGES-1 are masked to 0; bit 0 stays honoured.
    - `flush`=0 and `new_pc_valid`=0.
    - The counter decrements each cycle; at 1 the FSM returns to IDLE.
- **`flush_req` in FLUSH or RECOVER** is accepted:
  - `new_pc` is reloaded.
  - The FSM goes to FLUSH next cycle, restarting recovery.
- **Flush dominates stall:** `flush_req` in the same cycle as any `stallreq` still takes the FLUSH path. The stall decode applies in that request cycle only.
- **`stall_cnt`:** increments on every cycle with `stall[0]`=1 and saturates at all-ones. It is not cleared by flush.
- **Reset mid-operation:** state goes to IDLE immediately and all outputs take their reset values. This includes an in-progress FLUSH or RECOVER.

## Timing
- Reset values:
  - `stall`=0, `flush`=0, `new_pc_valid`=0, `new_pc`=0.
  - `stall_cnt`=0, `stall_timeout`=0.
  - state IDLE, recovery counter 0.
- `stall` has zero latency from `stallreq` in IDLE and RECOVER (combinational).
- Flush latency:
  - `flush_req` high in cycle t gives `flush` and `new_pc_valid` high in cycle t+1 only.
  - RECOVER covers cycles t+2 .. t+1+RECOVER_CYCLES; IDLE resumes at t+2+RECOVER_CYCLES.
- `flush`, `new_pc_valid` and `new_pc` are registered outputs.
- `stall_cnt` and `stall_timeout` are registered and update the cycle after the qualifying `stall[0]`.

## Configuration
- Macro: `PIPE_CTRL_WDOG_EN`.
- With the macro defined:
  - A consecutive-stall counter increments while `stall[0]`=1.
  - It clears on any cycle with `stall[0]`=0 or in FLUSH.
  - When it reaches WDOG_LIMIT, `stall_timeout` sets and stays set until `rst`.
- Without the macro: the counter logic is absent and `stall_timeout` is tied to 0.

## Test plan
All scenarios use STAGES=6, RECOVER_CYCLES=2, WDOG_LIMIT=4 unless stated.
- **Reset:** assert `rst` asynchronously mid-cycle → all outputs 0 before the next edge; state IDLE.
- **Stall decode:**
  - `stallreq`=6'b000100 (ID) → `stall`=6'b000111.
  - `stallreq`=6'b001100 (ID and EX) → `stall`=6'b001111.
  - After 3 such cycles, `stall_cnt`=3.
- **Flush:** `flush_req`=1 with `flush_pc`=32'hBFC00380 and `stallreq`=6'b001000 at cycle t.
  - Cycle t: `stall`=6'b001111.
  - Cycle t+1: `flush`=6'b111111, `new_pc_valid`=1, `new_pc`=32'hBFC00380, `stall`=0.
- **Recovery masking:** `stallreq`=6'b000100 held through t+2..t+3 → `stall`=0 in t+2 and t+3, then 6'b000111 at t+4.
- **Back-to-back flush:** second `flush_req` with target 32'h80000000 at t+2 → `flush`=all ones at t+3, `new_pc`=32'h80000000, recovery restarts.
- **Watchdog:**
  - With `PIPE_CTRL_WDOG_EN`: `stallreq`=6'b000001 held 4 cycles → `stall_timeout`=1 after the 4th edge and stays 1 after the request drops.
  - Without the macro: `stall_timeout` stays 0.
